// File: rtl/serial_tx.sv
// Memory-mapped 8N1 serial transmitter on the tenyr operand bus.
// Data writes are queued in a small FIFO; a status register reports FIFO and framing state.
`timescale 1ns/1ps

module serial_tx #(
    parameter int unsigned BASE   = 8,
    parameter int unsigned CLKDIV = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        rw,
    input  logic [31:0] addr,
    inout  wire  [31:0] data,
    output logic        txd
);

    localparam int unsigned PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW        = PW + 1;
    localparam logic [15:0] DIV_LOAD  = 16'(CLKDIV - 1);
    localparam logic [31:0] ADDR_DATA = 32'(BASE);
    localparam logic [31:0] ADDR_STAT = 32'(BASE + 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t         r_state;
    logic [15:0]    r_div;
    logic [2:0]     r_bit;
    logic [7:0]     r_shift;
    logic           r_txd;
    logic [7:0]     r_mem [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           r_ovf;

    state_t         w_state_nxt;
    logic [15:0]    w_div_nxt;
    logic [2:0]     w_bit_nxt;
    logic [7:0]     w_shift_nxt;
    logic           w_txd_nxt;
    logic           w_pop;

    logic           w_hit_data;
    logic           w_hit_stat;
    logic           w_rd;
    logic           w_push;
    logic           w_push_ok;
    logic           w_ovf_set;
    logic           w_ovf_clr;
    logic           w_full;
    logic           w_empty;
    logic           w_div_zero;
    logic [2:0]     w_bit_inc;
    logic [7:0]     w_head;
    logic [31:0]    w_status;
    logic [31:0]    w_rdata;
    logic [23:0]    w_unused_data;

    // Bus decode; the block ignores every address other than its two registers.
    assign w_hit_data = enable && (addr == ADDR_DATA);
    assign w_hit_stat = enable && (addr == ADDR_STAT);
    assign w_rd       = !rw && (w_hit_data || w_hit_stat);
    assign w_push     = rw && w_hit_data && !reset;
    assign w_ovf_clr  = rw && w_hit_stat && data[3] && !reset;

    assign w_full     = (r_count == FIFO_FULL);
    assign w_empty    = (r_count == '0);
    assign w_head     = r_mem[r_rptr];
    assign w_div_zero = (r_div == 16'd0);
    assign w_bit_inc  = r_bit + 3'd1;

    // A pop frees a slot on the same edge, so a full FIFO still accepts the push.
    assign w_push_ok  = w_push && (!w_full || w_pop);
    assign w_ovf_set  = w_push && w_full && !w_pop;

    assign w_status = {16'd0, 8'(r_count), 4'd0, r_ovf, (r_state != ST_IDLE), w_empty, w_full};
    assign w_rdata  = w_hit_stat ? w_status : 32'd0;
    assign data     = w_rd ? w_rdata : {32{1'bz}};
    assign txd      = r_txd;

    assign w_unused_data = data[31:8];

    // Frame sequencer: next state, bit timing and the next txd level.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_txd_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_div_nxt   = DIV_LOAD;
                    w_txd_nxt   = 1'b0;
                    w_state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (w_div_zero) begin
                    w_bit_nxt   = 3'd0;
                    w_div_nxt   = DIV_LOAD;
                    w_txd_nxt   = r_shift[0];
                    w_state_nxt = ST_DATA;
                end else begin
                    w_div_nxt = r_div - 16'd1;
                end
            end

            ST_DATA: begin
                if (w_div_zero) begin
                    w_div_nxt = DIV_LOAD;
                    if (r_bit == 3'd7) begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_nxt = w_bit_inc;
                        w_txd_nxt = r_shift[w_bit_inc];
                    end
                end else begin
                    w_div_nxt = r_div - 16'd1;
                end
            end

            ST_STOP: begin
                if (w_div_zero) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_div_nxt   = DIV_LOAD;
                        w_txd_nxt   = 1'b0;
                        w_state_nxt = ST_START;
                    end else begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_div_nxt = r_div - 16'd1;
                end
            end

            default: begin
                w_txd_nxt   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_div   <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    // FIFO bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= data[7:0];
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx: directed vector table, hand sequences for framing corners,
// and random bus traffic checked against a queue-based transmitter model.
`timescale 1ns/1ps

module tb_serial_tx;

    localparam int unsigned BASE   = 8;
    localparam int unsigned CLKDIV = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int          FRAME  = 10 * int'(CLKDIV);

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rw;
    logic [31:0] addr;
    wire  [31:0] data;
    logic        txd;

    logic        tb_drv;
    logic [31:0] tb_val;

    assign data = tb_drv ? tb_val : {32{1'bz}};

    always #5 clk = ~clk;

    serial_tx #(.BASE(BASE), .CLKDIV(CLKDIV), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .rw     (rw),
        .addr   (addr),
        .data   (data),
        .txd    (txd)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue plus "frame in flight" with a cycle offset.
    logic [7:0] mq[$];
    logic       m_ovf    = 1'b0;
    logic       m_active = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_cur    = 8'd0;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s       = 32'd0;
        s[0]    = (mq.size() == int'(DEPTH));
        s[1]    = (mq.size() == 0);
        s[2]    = m_active;
        s[3]    = m_ovf;
        s[15:8] = 8'(mq.size());
        return s;
    endfunction

    function automatic logic m_txd();
        int k;
        if (!m_active) return 1'b1;
        k = m_t / int'(CLKDIV);
        if (k == 0) return 1'b0;
        if (k <= 8) return m_cur[k-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input logic rst, input logic push, input logic [7:0] b,
                              input logic clr);
        int   sz;
        logic pop;
        if (rst) begin
            mq.delete();
            m_ovf    = 1'b0;
            m_active = 1'b0;
            m_t      = 0;
            return;
        end
        sz  = mq.size();
        pop = (sz > 0) && (!m_active || m_t == FRAME - 1);
        if (m_active) begin
            m_t++;
            if (m_t == FRAME) m_active = 1'b0;
        end
        if (pop) begin
            m_cur    = mq.pop_front();
            m_active = 1'b1;
            m_t      = 0;
        end
        if (push) begin
            if (sz < int'(DEPTH) || pop) mq.push_back(b);
            else m_ovf = 1'b1;
        end
        if (clr) m_ovf = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive, check the bus before the edge, advance, check txd after it.
    task automatic step(input logic rst, input logic en, input logic w,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd);
        logic hit;
        reset  = rst;
        enable = en;
        rw     = w;
        addr   = a;
        hit    = en && (a == BASE || a == BASE + 1);
        if (en && w) begin
            tb_drv = 1'b1;
            tb_val = wd;
        end else if (hit) begin
            tb_drv = 1'b0;
            tb_val = 32'd0;
        end else begin
            tb_drv = 1'b1;
            tb_val = 32'd0;
        end
        #1;
        rd = data;
        if (en && !w && hit) chk("bus_read", data, (a == BASE) ? 32'd0 : m_status());
        else chk("bus_undriven", data, tb_val);
        @(posedge clk);
        model_edge(rst, en && w && (a == BASE), wd[7:0], en && w && (a == BASE + 1) && wd[3]);
        #1;
        chk("txd_model", 32'(txd), 32'(m_txd()));
    endtask

    task automatic idle(input int n);
        logic [31:0] rd;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, rd);
    endtask

    typedef struct {
        logic        en;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_txd;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [31:0] rd;
        logic [9:0]  pat41;

        reset  = 1'b1;
        enable = 1'b0;
        rw     = 1'b0;
        addr   = 32'd0;
        tb_drv = 1'b1;
        tb_val = 32'd0;

        vt[0] = '{1'b1, 1'b0, BASE + 1, 32'd0,          1'b1, 32'h0000_0002, 1'b1};
        vt[1] = '{1'b1, 1'b0, BASE,     32'd0,          1'b1, 32'h0000_0000, 1'b1};
        vt[2] = '{1'b1, 1'b1, BASE + 2, 32'h0000_0055, 1'b0, 32'd0,         1'b1};
        vt[3] = '{1'b1, 1'b0, BASE + 2, 32'd0,          1'b0, 32'd0,         1'b1};
        vt[4] = '{1'b1, 1'b0, BASE + 1, 32'd0,          1'b1, 32'h0000_0002, 1'b1};
        vt[5] = '{1'b1, 1'b1, BASE,     32'hABCD_EF41, 1'b0, 32'd0,         1'b1};
        vt[6] = '{1'b1, 1'b0, BASE + 1, 32'd0,          1'b1, 32'h0000_0100, 1'b0};
        vt[7] = '{1'b1, 1'b0, BASE + 1, 32'd0,          1'b1, 32'h0000_0006, 1'b0};

        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, rd);
        step(1'b1, 1'b1, 1'b1, BASE, 32'h0000_00FF, rd);
        chk("reset_txd", 32'(txd), 32'd1);

        foreach (vt[i]) begin
            step(1'b0, vt[i].en, vt[i].w, vt[i].a, vt[i].wd, rd);
            if (vt[i].chk_rd) chk($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_txd", i), 32'(txd), 32'(vt[i].exp_txd));
        end

        // 0x41 frame: start, LSB-first data, stop; edge offset c is 2..39 here.
        pat41 = 10'b10_0100_0001 << 1;
        pat41[9] = 1'b1;
        for (int c = 2; c < 40; c++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, rd);
            chk("frame41_bit", 32'(txd), 32'(pat41[c / int'(CLKDIV)]));
        end
        idle(1);
        step(1'b0, 1'b1, 1'b0, BASE + 1, 32'd0, rd);
        chk("frame41_done_status", rd, 32'h0000_0002);

        // Six back-to-back writes into a four-deep FIFO.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, BASE, 32'h10 + 32'(i), rd);
        step(1'b0, 1'b1, 1'b0, BASE + 1, 32'd0, rd);
        chk("overflow_status", rd, 32'h0000_040D);
        step(1'b0, 1'b1, 1'b1, BASE + 1, 32'h0000_0008, rd);
        step(1'b0, 1'b1, 1'b0, BASE + 1, 32'd0, rd);
        chk("ovf_clear_status", rd, 32'h0000_0405);
        idle(200);
        step(1'b0, 1'b1, 1'b0, BASE + 1, 32'd0, rd);
        chk("drained_status", rd, 32'h0000_0002);

        // Reset partway through a frame with two bytes still queued.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, BASE, 32'hA1 + 32'(i), rd);
        idle(12);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, rd);
        chk("midframe_reset_txd", 32'(txd), 32'd1);
        step(1'b0, 1'b1, 1'b0, BASE + 1, 32'd0, rd);
        chk("midframe_reset_status", rd, 32'h0000_0002);
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, rd);
            chk("post_reset_quiet", 32'(txd), 32'd1);
        end

        // Random bus traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r_en;
            logic        r_w;
            logic        r_rst;
            logic [31:0] r_a;
            int          sel;
            r_en  = ($urandom % 4) != 0;
            r_w   = ($urandom % 3) == 0;
            r_rst = ($urandom % 600) == 0;
            sel   = int'($urandom % 8);
            case (sel)
                0, 1, 2: r_a = BASE;
                3, 4:    r_a = BASE + 1;
                5:       r_a = BASE + 2;
                6:       r_a = BASE - 1;
                default: r_a = $urandom;
            endcase
            step(r_rst, r_en, r_w, r_a, $urandom, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
